// File: rtl/ph_reg3_fifo.sv
// ----------------------------------------------------------------------------
// ph_reg3_fifo
//
// Host-side register-3 FIFO between a parasite writer and a host reader.
// Two 8-bit entries (slot0 is the head, slot1 behind it) and a 2-bit
// occupancy count in 0..2. The usable depth is 1 or 2 entries, selected by
// two_byte_mode. Both status flags report "count has reached the selected
// depth": the parasite sees that as full, the host sees it as data ready.
//
// Optional feature macro: PH_REG3_OVERRUN_FLAG_EN
//   When defined, the h_overrun port exists and is a sticky flag set by any
//   parasite write that arrives while p_full is high. It is cleared only by
//   reset or h_flush. When undefined, the port and its logic are absent and
//   such writes are dropped silently.
//
// Ports
//   h_phi2           in   sole clock, all state updates on the rising edge
//   h_rst_b          in   asynchronous active-low reset
//   p_data[7:0]      in   parasite write data
//   p_wr             in   one-cycle parasite write strobe (synchronous to h_phi2)
//   h_rd             in   host read/not-write, high means read
//   h_selectData     in   host register-3 data select
//   two_byte_mode    in   1 = two-entry depth, 0 = one-entry depth
//   h_flush          in   synchronous clear (count and overrun only)
//   h_data[7:0]      out  head-of-FIFO byte (slot0 register)
//   h_data_available out  count has reached the selected depth
//   h_overrun        out  sticky overrun flag (only with the macro defined)
//   p_full           out  parasite must not write
// ----------------------------------------------------------------------------
module ph_reg3_fifo (
    input  logic       h_phi2,
    input  logic       h_rst_b,
    input  logic [7:0] p_data,
    input  logic       p_wr,
    input  logic       h_rd,
    input  logic       h_selectData,
    input  logic       two_byte_mode,
    input  logic       h_flush,
    output logic [7:0] h_data,
    output logic       h_data_available,
`ifdef PH_REG3_OVERRUN_FLAG_EN
    output logic       h_overrun,
`endif
    output logic       p_full
);

    // Value both slots take out of reset; the host reads it as 'A'.
    localparam logic [7:0] RESET_BYTE = 8'h41;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0] count_r;
    logic [7:0] slot0_r;
    logic [7:0] slot1_r;

    // ------------------------------------------------------------------
    // Decoded controls and next-state values
    // ------------------------------------------------------------------
    logic [1:0] limit_s;
    logic       full_s;
    logic       wr_accept_s;
    logic       pop_s;
    logic [1:0] count_nxt_s;
    logic [7:0] slot0_nxt_s;
    logic [7:0] slot1_nxt_s;

`ifdef PH_REG3_OVERRUN_FLAG_EN
    logic       overrun_r;
    logic       overrun_nxt_s;
    logic       wr_drop_s;
`endif

    // Selected depth: one or two entries.
    always_comb begin
        if (two_byte_mode) begin
            limit_s = 2'd2;
        end else begin
            limit_s = 2'd1;
        end
    end

    // Occupancy flag plus the accepted-write and pop qualifiers.
    // Full is derived only from registered count and the live mode input,
    // so a mode drop with two bytes stored keeps the flags asserted.
    always_comb begin
        full_s      = (count_r >= limit_s);
        wr_accept_s = p_wr & ~full_s;
        pop_s       = h_selectData & h_rd & (count_r != 2'd0);
    end

    // Next storage and count. A pop shifts slot1 into slot0; a write lands
    // at index count, or at count-1 when it coincides with a pop (the shift
    // happens first). Flush only zeroes the count, so the slots keep their
    // old contents and h_data does not change on a flush.
    always_comb begin
        count_nxt_s = count_r;
        slot0_nxt_s = slot0_r;
        slot1_nxt_s = slot1_r;
        if (h_flush) begin
            count_nxt_s = 2'd0;
        end else begin
            case ({wr_accept_s, pop_s})
                2'b10: begin
                    case (count_r)
                        2'd0:    slot0_nxt_s = p_data;
                        2'd1:    slot1_nxt_s = p_data;
                        default: slot1_nxt_s = slot1_r;
                    endcase
                    count_nxt_s = count_r + 2'd1;
                end
                2'b01: begin
                    slot0_nxt_s = slot1_r;
                    count_nxt_s = count_r - 2'd1;
                end
                2'b11: begin
                    // Count is unchanged; the new byte fills the slot the
                    // shift just vacated.
                    case (count_r)
                        2'd2: begin
                            slot0_nxt_s = slot1_r;
                            slot1_nxt_s = p_data;
                        end
                        default: slot0_nxt_s = p_data;
                    endcase
                end
                default: begin
                    count_nxt_s = count_r;
                end
            endcase
        end
    end

    // Storage and count registers; reset aborts any in-flight operation.
    always_ff @(posedge h_phi2 or negedge h_rst_b) begin
        if (!h_rst_b) begin
            count_r <= 2'd0;
            slot0_r <= RESET_BYTE;
            slot1_r <= RESET_BYTE;
        end else begin
            count_r <= count_nxt_s;
            slot0_r <= slot0_nxt_s;
            slot1_r <= slot1_nxt_s;
        end
    end

`ifdef PH_REG3_OVERRUN_FLAG_EN
    // Sticky overrun: set by a write arriving while full, flush wins.
    always_comb begin
        wr_drop_s = p_wr & full_s;
        if (h_flush) begin
            overrun_nxt_s = 1'b0;
        end else if (wr_drop_s) begin
            overrun_nxt_s = 1'b1;
        end else begin
            overrun_nxt_s = overrun_r;
        end
    end

    // Overrun flag register.
    always_ff @(posedge h_phi2 or negedge h_rst_b) begin
        if (!h_rst_b) begin
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= overrun_nxt_s;
        end
    end

    assign h_overrun = overrun_r;
`endif

    // Output drive: head byte straight from its register, flags from count.
    assign h_data           = slot0_r;
    assign h_data_available = full_s;
    assign p_full           = full_s;

endmodule

// File: tb/tb_ph_reg3_fifo.sv
// ----------------------------------------------------------------------------
// tb_ph_reg3_fifo
//
// Self-checking bench for ph_reg3_fifo. A reference model keeps the two
// storage bytes as a plain array indexed by occupancy and applies the
// documented pop/write/flush rules in order each cycle. Directed scenarios
// are followed by a randomized run with occasional asynchronous resets.
// Build with +define+PH_REG3_OVERRUN_FLAG_EN to also check h_overrun.
// ----------------------------------------------------------------------------
module tb_ph_reg3_fifo;

    logic       h_phi2 = 1'b0;
    logic       h_rst_b;
    logic [7:0] p_data;
    logic       p_wr;
    logic       h_rd;
    logic       h_selectData;
    logic       two_byte_mode;
    logic       h_flush;
    logic [7:0] h_data;
    logic       h_data_available;
    logic       p_full;
`ifdef PH_REG3_OVERRUN_FLAG_EN
    logic       h_overrun;
`endif

    ph_reg3_fifo dut (
        .h_phi2           (h_phi2),
        .h_rst_b          (h_rst_b),
        .p_data           (p_data),
        .p_wr             (p_wr),
        .h_rd             (h_rd),
        .h_selectData     (h_selectData),
        .two_byte_mode    (two_byte_mode),
        .h_flush          (h_flush),
        .h_data           (h_data),
        .h_data_available (h_data_available),
`ifdef PH_REG3_OVERRUN_FLAG_EN
        .h_overrun        (h_overrun),
`endif
        .p_full           (p_full)
    );

    // 10 time-unit clock.
    always #5 h_phi2 = ~h_phi2;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    int         m_cnt;
    logic [7:0] m_mem [0:1];
    bit         m_ovr;

    // Single comparison point for every check in the bench.
    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt    = 0;
        m_mem[0] = 8'h41;
        m_mem[1] = 8'h41;
        m_ovr    = 1'b0;
    endtask

    // One clock of the documented behaviour, given the inputs of that cycle.
    task automatic model_step(input logic wr, input logic [7:0] d, input logic sel,
                              input logic rd, input logic mode, input logic flush);
        int  lim;
        bit  full;
        bit  do_pop;
        lim    = mode ? 2 : 1;
        full   = (m_cnt >= lim);
        do_pop = sel && rd && (m_cnt > 0);
        if (flush) begin
            m_cnt = 0;
            m_ovr = 1'b0;
        end else begin
            if (do_pop) begin
                m_mem[0] = m_mem[1];
                m_cnt    = m_cnt - 1;
            end
            if (wr && !full) begin
                m_mem[m_cnt] = d;
                m_cnt        = m_cnt + 1;
            end
            if (wr && full) m_ovr = 1'b1;
        end
    endtask

    task automatic check_outputs(input string tag);
        logic flag;
        flag = (m_cnt >= (two_byte_mode ? 2 : 1));
        check({tag, "/h_data"}, h_data, m_mem[0]);
        check({tag, "/avail"}, {7'd0, h_data_available}, {7'd0, flag});
        check({tag, "/p_full"}, {7'd0, p_full}, {7'd0, flag});
`ifdef PH_REG3_OVERRUN_FLAG_EN
        check({tag, "/overrun"}, {7'd0, h_overrun}, {7'd0, m_ovr});
`endif
    endtask

    // Drive one cycle of inputs (called just after a rising edge), advance
    // the model, then check the outputs just after the next rising edge.
    task automatic step(input string tag, input logic wr, input logic [7:0] d,
                        input logic sel, input logic rd, input logic mode,
                        input logic flush);
        p_wr          = wr;
        p_data        = d;
        h_selectData  = sel;
        h_rd          = rd;
        two_byte_mode = mode;
        h_flush       = flush;
        model_step(wr, d, sel, rd, mode, flush);
        @(posedge h_phi2);
        #1;
        check_outputs(tag);
    endtask

    // Asynchronous reset pulse while a write and a pop are being requested.
    task automatic reset_pulse(input string tag);
        p_wr         = 1'b1;
        p_data       = 8'hEE;
        h_selectData = 1'b1;
        h_rd         = 1'b1;
        #2;
        h_rst_b = 1'b0;
        model_reset();
        #1;
        check_outputs({tag, "/async"});
        @(posedge h_phi2);
        #1;
        check_outputs({tag, "/held"});
        h_rst_b = 1'b1;
    endtask

    initial begin
        h_rst_b       = 1'b0;
        p_data        = 8'h00;
        p_wr          = 1'b0;
        h_rd          = 1'b0;
        h_selectData  = 1'b0;
        two_byte_mode = 1'b1;
        h_flush       = 1'b0;
        model_reset();
        #12;
        check("rst/h_data", h_data, 8'h41);
        check("rst/avail", {7'd0, h_data_available}, 8'h00);
        check("rst/p_full", {7'd0, p_full}, 8'h00);
`ifdef PH_REG3_OVERRUN_FLAG_EN
        check("rst/overrun", {7'd0, h_overrun}, 8'h00);
`endif
        @(posedge h_phi2);
        #1;
        h_rst_b = 1'b1;

        // Two-byte mode: flags only after the second write, then pop twice.
        step("r32_w1", 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
        check("r32_avail_after_w1", {7'd0, h_data_available}, 8'h00);
        step("r32_w2", 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
        check("r32_avail_after_w2", {7'd0, h_data_available}, 8'h01);
        check("r32_head", h_data, 8'hA5);
        step("r32_p1", 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
        check("r32_head_after_p1", h_data, 8'h3C);
        step("r32_p2", 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
        check("r32_full_after_p2", {7'd0, p_full}, 8'h00);
        step("r32_pop_empty", 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);

        // One-byte mode: second write dropped, overrun raised.
        step("r33_w1", 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
        step("r33_w2", 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
        check("r33_head", h_data, 8'h11);
`ifdef PH_REG3_OVERRUN_FLAG_EN
        check("r33_overrun", {7'd0, h_overrun}, 8'h01);
`endif

        // Simultaneous write and pop at count 1 (two-byte depth).
        step("r34_flush", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        step("r34_w", 1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
        step("r34_wp", 1'b1, 8'h66, 1'b1, 1'b1, 1'b1, 1'b0);
        check("r34_head", h_data, 8'h66);
        step("r34_w2", 1'b1, 8'h67, 1'b0, 1'b0, 1'b1, 1'b0);
        check("r34_full_count2", {7'd0, p_full}, 8'h01);

        // Overrun at count 2, then flush against a write.
        step("r35_drop", 1'b1, 8'h99, 1'b0, 1'b0, 1'b1, 1'b0);
        step("r35_flush", 1'b1, 8'h9A, 1'b0, 1'b0, 1'b1, 1'b1);
        check("r35_avail", {7'd0, h_data_available}, 8'h00);
        check("r35_full", {7'd0, p_full}, 8'h00);
        check("r35_head_kept", h_data, 8'h66);

        // Mode drop with two bytes stored, then one pop.
        step("r36_w1", 1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 1'b0);
        step("r36_w2", 1'b1, 8'h88, 1'b0, 1'b0, 1'b1, 1'b0);
        step("r36_mode0", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("r36_full_after_drop", {7'd0, p_full}, 8'h01);
        step("r36_pop", 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        check("r36_head", h_data, 8'h88);
        check("r36_avail", {7'd0, h_data_available}, 8'h01);

        // Reset in the middle of activity.
        reset_pulse("r28");
        step("r29_resume", 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                reset_pulse("rnd_rst");
            end else begin
                step("rnd",
                     1'($urandom_range(0, 99) < 55),
                     8'($urandom),
                     1'($urandom_range(0, 99) < 60),
                     1'($urandom_range(0, 99) < 70),
                     1'($urandom_range(0, 99) < 75 ? two_byte_mode : ~two_byte_mode),
                     1'($urandom_range(0, 15) == 0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ph_reg3_fifo.md
PH_REG3_FIFO -- requirements
Module: ph_reg3_fifo

Interface
REQ-001 SHALL have port h_phi2  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port h_rst_b  input  1  asynchronous active-low reset.
REQ-003 SHALL have port p_data  input  8  parasite write data.
REQ-004 SHALL have port p_wr  input  1  one-cycle parasite write strobe, already synchronised to h_phi2.
REQ-005 SHALL have port h_rd  input  1  host read/not-write; high means read.
REQ-006 SHALL have port h_selectData  input  1  host register-3 data select.
REQ-007 SHALL have port two_byte_mode  input  1  1 = 2-byte depth; 0 = 1-byte depth.
REQ-008 SHALL have port h_flush  input  1  synchronous clear from the control register.
REQ-009 SHALL have port h_data  output  8  head-of-FIFO byte.
REQ-010 SHALL have port h_data_available  output  1  host may read.
REQ-011 SHALL have port p_full  output  1  parasite must not write.
REQ-012 SHALL have port h_overrun  output  1  sticky overrun flag; present only under REQ-030.

Function
REQ-013 SHALL hold two 8-bit entries (slot0 = head, slot1) and a 2-bit count in 0..2.
REQ-014 SHALL define limit = 2 when two_byte_mode = 1, else 1.
REQ-015 SHALL drive p_full = (count >= limit), combinationally from registered count and two_byte_mode.
REQ-016 SHALL drive h_data_available = (count >= limit), so the host sees data only when the selected depth is filled.
REQ-017 SHALL drive h_data = slot0, registered; h_data is unchanged while count = 0.
REQ-018 SHALL treat a write as accepted when p_wr = 1 and p_full = 0 in that cycle; data lands in slot[count]; count+1.
REQ-019 SHALL treat a pop as occurring when h_selectData = 1, h_rd = 1 and count > 0 in that cycle; slot1 shifts into slot0; count-1.
REQ-020 SHALL apply a pop to an empty FIFO (count = 0) as a no-op with no state change.
REQ-021 SHALL, on a simultaneous accepted write and pop, leave count unchanged; the new byte lands in slot[count-1] after the shift.
REQ-022 SHALL ignore a write while p_full = 1; storage and count are unchanged.
REQ-023 SHALL give one-cycle latency: an accepted write is visible on count and flags at the next rising edge.
REQ-024 SHALL, when two_byte_mode falls to 0 with count = 2, keep both bytes; flags follow REQ-015/016 (both asserted) until pops reduce count.
REQ-025 SHALL, when h_flush = 1, set count = 0 and clear h_overrun, with priority over writes and pops in the same cycle; slot contents are retained.

Reset
REQ-026 SHALL, on h_rst_b low, immediately and asynchronously set count = 0 and slot0 = slot1 = 8'h41.
REQ-027 SHALL have reset values h_data = 8'h41, h_data_available = 0, p_full = 0, h_overrun = 0.
REQ-028 SHALL abort a mid-operation write or pop when reset is asserted; no partial state survives.
REQ-029 SHALL resume normal operation at the first rising edge after h_rst_b deasserts.

Configuration
REQ-030 SHALL, with PH_REG3_OVERRUN_FLAG_EN defined:
- include port h_overrun;
- set h_overrun on any ignored write (REQ-022);
- hold h_overrun until reset or h_flush.
Without the macro, the port and its logic SHALL be absent, and ignored writes SHALL be silently dropped.

Verification
REQ-031 SHALL cover reset: pulse h_rst_b low -> h_data = 8'h41, h_data_available = 0, p_full = 0, h_overrun = 0.
REQ-032 SHALL cover two-byte mode:
- stimulus: two_byte_mode = 1; write 8'hA5 then 8'h3C.
- response: flags assert only after the second write.
- then pop twice: h_data reads A5, then 3C; both flags clear.
REQ-033 SHALL cover one-byte mode and overrun:
- stimulus: two_byte_mode = 0; write 8'h11, then write 8'h22.
- response: second write ignored; h_data = 8'h11; h_overrun = 1 when enabled.
REQ-034 SHALL cover simultaneous write and pop:
- stimulus: count = 1 holding 8'h55; in one cycle, pop and write 8'h66.
- response: count stays 1; h_data = 8'h66.
REQ-035 SHALL cover flush against a write:
- stimulus: count = 2; assert h_flush with p_wr in the same cycle.
- response: count = 0; both flags low; h_overrun cleared.
REQ-036 SHALL cover mode change with a full FIFO:
- stimulus: count = 2; drop two_byte_mode to 0; pop once.
- response: h_data shows the second byte; flags remain asserted with count = 1.
